// File: rtl/affine_sched_ctrl.sv
// Affine schedule controller: one enable pulse per iteration of a 3-deep loop nest
// at cycle OFFSET + d0*STR0 + d1*STR1 + d2*STR2 after flush release.
module affine_sched_ctrl #(
    parameter int CW     = 16,
    parameter int EXT0   = 4,
    parameter int EXT1   = 4,
    parameter int EXT2   = 1,
    parameter int STR0   = 1,
    parameter int STR1   = 4,
    parameter int STR2   = 16,
    parameter int OFFSET = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          stall,
    output logic          en,
    output logic [CW-1:0] d0,
    output logic [CW-1:0] d1,
    output logic [CW-1:0] d2,
    output logic          busy,
    output logic          done
);

    localparam longint LAST_FIRE = longint'(OFFSET)
                                 + longint'(EXT0 - 1) * longint'(STR0)
                                 + longint'(EXT1 - 1) * longint'(STR1)
                                 + longint'(EXT2 - 1) * longint'(STR2);

    generate
        if (LAST_FIRE >= (longint'(1) << CW)) begin : g_range_chk
            $error("affine_sched_ctrl: last fire time does not fit in CW bits");
        end
    endgenerate

    // Sum of products is formed wide, then truncated; the range check above bounds it.
    localparam int MW = CW + $clog2(STR0 + STR1 + STR2 + OFFSET + 1) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fire;
    logic [CW-1:0] nd0;
    logic [CW-1:0] nd1;
    logic [CW-1:0] nd2;
    logic          final_iter;
    logic          fire_now;

    function automatic logic [CW-1:0] fire_of(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b,
                                              input logic [CW-1:0] c);
        logic [MW-1:0] sum;
        sum = MW'(OFFSET)
            + MW'(a) * MW'(STR0)
            + MW'(b) * MW'(STR1)
            + MW'(c) * MW'(STR2);
        return sum[CW-1:0];
    endfunction

    // Innermost-first index advance; wrapping out of d2 marks the final iteration.
    always_comb begin
        nd0        = d0;
        nd1        = d1;
        nd2        = d2;
        final_iter = 1'b0;
        if (d0 != CW'(EXT0 - 1)) begin
            nd0 = d0 + CW'(1);
        end else begin
            nd0 = '0;
            if (d1 != CW'(EXT1 - 1)) begin
                nd1 = d1 + CW'(1);
            end else begin
                nd1 = '0;
                if (d2 != CW'(EXT2 - 1)) begin
                    nd2 = d2 + CW'(1);
                end else begin
                    nd2        = '0;
                    final_iter = 1'b1;
                end
            end
        end
    end

    assign fire_now = (state == RUN) && !flush && !stall && (cnt == fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else if (fire_now && final_iter) begin
            state_nxt = DONE;
        end
    end

    always_comb begin
        en   = fire_now;
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Schedule time only advances while running and not stalled; DONE freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fire <= CW'(OFFSET);
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
        end else if (flush) begin
            cnt  <= '0;
            fire <= CW'(OFFSET);
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
        end else if (state == RUN && !stall) begin
            cnt <= cnt + CW'(1);
            if (fire_now) begin
                d0   <= nd0;
                d1   <= nd1;
                d2   <= nd2;
                fire <= fire_of(nd0, nd1, nd2);
            end
        end
    end

endmodule

// File: tb/tb_affine_sched_ctrl.sv
// Bench for affine_sched_ctrl: four parameterisations checked against a fire-time list model,
// with directed vector tables and hand sequences for stall, flush, reset and single-iteration cases.
module tb_affine_sched_ctrl;

    localparam int NI = 4;
    localparam int MAXN = 32;

    logic        clk;
    logic        rst_n;
    logic        flush_i [NI];
    logic        stall_i [NI];
    logic        en_o    [NI];
    logic        busy_o  [NI];
    logic        done_o  [NI];
    logic [15:0] d0_o    [NI];
    logic [15:0] d1_o    [NI];
    logic [15:0] d2_o    [NI];

    int n_cmp = 0;
    int n_bad = 0;

    // Instance parameters, mirrored for the model.
    int p_ext0 [NI] = '{4, 4, 1, 3};
    int p_ext1 [NI] = '{4, 4, 1, 2};
    int p_ext2 [NI] = '{1, 1, 1, 3};
    int p_str0 [NI] = '{1, 1, 1, 2};
    int p_str1 [NI] = '{4, 6, 1, 7};
    int p_str2 [NI] = '{16, 32, 16, 20};
    int p_off  [NI] = '{2, 2, 0, 3};

    // Model: ordered list of (fire time, indices) per instance, plus schedule time and position.
    int n_it [NI];
    int ft   [NI][MAXN];
    int e0   [NI][MAXN];
    int e1   [NI][MAXN];
    int e2   [NI][MAXN];
    int mode [NI];
    int t_m  [NI];
    int k_m  [NI];

    affine_sched_ctrl u0 (.clk(clk), .rst_n(rst_n), .flush(flush_i[0]), .stall(stall_i[0]),
        .en(en_o[0]), .d0(d0_o[0]), .d1(d1_o[0]), .d2(d2_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    affine_sched_ctrl #(.CW(16), .EXT0(4), .EXT1(4), .EXT2(1), .STR0(1), .STR1(6), .STR2(32), .OFFSET(2)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush_i[1]), .stall(stall_i[1]),
        .en(en_o[1]), .d0(d0_o[1]), .d1(d1_o[1]), .d2(d2_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    affine_sched_ctrl #(.CW(16), .EXT0(1), .EXT1(1), .EXT2(1), .STR0(1), .STR1(1), .STR2(16), .OFFSET(0)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush_i[2]), .stall(stall_i[2]),
        .en(en_o[2]), .d0(d0_o[2]), .d1(d1_o[2]), .d2(d2_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    affine_sched_ctrl #(.CW(16), .EXT0(3), .EXT1(2), .EXT2(3), .STR0(2), .STR1(7), .STR2(20), .OFFSET(3)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(flush_i[3]), .stall(stall_i[3]),
        .en(en_o[3]), .d0(d0_o[3]), .d1(d1_o[3]), .d2(d2_o[3]), .busy(busy_o[3]), .done(done_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_en(input int i);
        return (mode[i] == 1) && !flush_i[i] && !stall_i[i] && (t_m[i] == ft[i][k_m[i]]);
    endfunction

    task automatic model_check(input int i);
        int x0, x1, x2;
        x0 = (mode[i] == 1) ? e0[i][k_m[i]] : 0;
        x1 = (mode[i] == 1) ? e1[i][k_m[i]] : 0;
        x2 = (mode[i] == 1) ? e2[i][k_m[i]] : 0;
        chk($sformatf("en[%0d]", i),   int'(en_o[i]),   int'(model_en(i)));
        chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(mode[i] == 1));
        chk($sformatf("done[%0d]", i), int'(done_o[i]), int'(mode[i] == 2));
        chk($sformatf("d0[%0d]", i),   int'(d0_o[i]),   x0);
        chk($sformatf("d1[%0d]", i),   int'(d1_o[i]),   x1);
        chk($sformatf("d2[%0d]", i),   int'(d2_o[i]),   x2);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mode[i] = 0;
            t_m[i]  = 0;
            k_m[i]  = 0;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit fired;
        @(negedge clk);
        for (int i = 0; i < NI; i++) model_check(i);
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                mode[i] = 0; t_m[i] = 0; k_m[i] = 0;
            end else if (flush_i[i]) begin
                mode[i] = 1; t_m[i] = 0; k_m[i] = 0;
            end else if (mode[i] == 1 && !stall_i[i]) begin
                fired = model_en(i);
                t_m[i]++;
                if (fired) begin
                    k_m[i]++;
                    if (k_m[i] == n_it[i]) begin
                        mode[i] = 2;
                        k_m[i]  = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            flush_i[i] = 1'b0;
            stall_i[i] = 1'b0;
        end
    endtask

    typedef struct {
        int inst;
        bit fl;
        bit st;
        bit x_en;
        int x_d0;
        int x_d1;
        bit x_done;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   p;
        int   pulses;
        int   first;

        // Fire-time lists straight from the loop-nest definition.
        for (int i = 0; i < NI; i++) begin
            n_it[i] = 0;
            for (int c = 0; c < p_ext2[i]; c++)
                for (int b = 0; b < p_ext1[i]; b++)
                    for (int a = 0; a < p_ext0[i]; a++) begin
                        ft[i][n_it[i]] = p_off[i] + a * p_str0[i] + b * p_str1[i] + c * p_str2[i];
                        e0[i][n_it[i]] = a;
                        e1[i][n_it[i]] = b;
                        e2[i][n_it[i]] = c;
                        n_it[i]++;
                    end
        end

        // Instance 0: stall during cycles 5..7.
        v = '{inst: 0, fl: 1, st: 0, x_en: 0, x_d0: 0, x_d1: 0, x_done: 0};
        tbl.push_back(v);
        for (int c = 0; c <= 21; c++) begin
            p = (c < 5) ? c - 2 : c - 5;
            v.inst   = 0;
            v.fl     = 0;
            v.st     = (c >= 5 && c <= 7);
            v.x_en   = (c >= 2 && c <= 4) || (c >= 8 && c <= 20);
            v.x_d0   = (p >= 0) ? p % 4 : 0;
            v.x_d1   = (p >= 0) ? p / 4 : 0;
            v.x_done = (c >= 21);
            tbl.push_back(v);
        end
        // Instance 1: sparse schedule, groups of four every six cycles.
        v = '{inst: 1, fl: 1, st: 0, x_en: 0, x_d0: 0, x_d1: 0, x_done: 0};
        tbl.push_back(v);
        for (int c = 0; c <= 25; c++) begin
            v.inst   = 1;
            v.fl     = 0;
            v.st     = 0;
            v.x_en   = (c >= 2) && (c <= 23) && (((c - 2) % 6) < 4);
            v.x_d0   = (c - 2) % 6;
            v.x_d1   = (c - 2) / 6;
            v.x_done = (c >= 24);
            tbl.push_back(v);
        end

        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy[%0d]", i), int'(busy_o[i]), 0);
            chk($sformatf("rst_done[%0d]", i), int'(done_o[i]), 0);
        end

        foreach (tbl[r]) begin
            flush_i[tbl[r].inst] = tbl[r].fl;
            stall_i[tbl[r].inst] = tbl[r].st;
            #3;
            chk($sformatf("tbl%0d_en", r),   int'(en_o[tbl[r].inst]),   int'(tbl[r].x_en));
            chk($sformatf("tbl%0d_done", r), int'(done_o[tbl[r].inst]), int'(tbl[r].x_done));
            if (tbl[r].x_en) begin
                chk($sformatf("tbl%0d_d0", r), int'(d0_o[tbl[r].inst]), tbl[r].x_d0);
                chk($sformatf("tbl%0d_d1", r), int'(d1_o[tbl[r].inst]), tbl[r].x_d1);
            end
            tick();
        end
        idle_inputs();

        // Flush mid-run on instance 0 after seven pulses.
        flush_i[0] = 1'b1;
        tick();
        flush_i[0] = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        flush_i[0] = 1'b1;
        #3;
        chk("midflush_en", int'(en_o[0]), 0);
        tick();
        flush_i[0] = 1'b0;
        chk("midflush_d0", int'(d0_o[0]), 0);
        chk("midflush_d1", int'(d1_o[0]), 0);
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 22; c++) begin
            #3;
            if (en_o[0]) begin
                if (first < 0) first = c;
                pulses++;
            end
            tick();
        end
        chk("refire_first", first, 2);
        chk("refire_count", pulses, 16);

        // Single-iteration nest: one pulse in cycle 0, repeated by a second flush.
        for (int rep = 0; rep < 2; rep++) begin
            flush_i[2] = 1'b1;
            #3;
            chk("single_en_flush", int'(en_o[2]), 0);
            tick();
            flush_i[2] = 1'b0;
            #3;
            chk("single_en_c0", int'(en_o[2]), 1);
            tick();
            #3;
            chk("single_en_c1", int'(en_o[2]), 0);
            chk("single_done_c1", int'(done_o[2]), 1);
            tick();
        end

        // Randomised flush/stall traffic on all instances.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                flush_i[i] = ($urandom_range(0, 59) == 0);
                stall_i[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        // Asynchronous reset mid-run, away from any clock edge.
        idle_inputs();
        for (int i = 0; i < NI; i++) flush_i[i] = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("arst_en[%0d]", i),   int'(en_o[i]),   0);
            chk($sformatf("arst_busy[%0d]", i), int'(busy_o[i]), 0);
            chk($sformatf("arst_done[%0d]", i), int'(done_o[i]), 0);
            chk($sformatf("arst_d0[%0d]", i),   int'(d0_o[i]),   0);
        end
        model_reset();
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) tick();
        for (int i = 0; i < NI; i++) flush_i[i] = 1'b1;
        tick();
        idle_inputs();
        pulses = 0;
        for (int c = 0; c < 70; c++) begin
            #3;
            if (en_o[0]) pulses++;
            tick();
        end
        chk("post_reset_count", pulses, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/affine_sched_ctrl.md
Name: affine_sched_ctrl

Overview:
- Affine schedule controller for a clockwork-generated accelerator stream port (e.g. a `raw_oc_raw_update_0_read_en` / `*_write_valid` pair).
- Emits one enable pulse per iteration of a 3-deep loop nest, at cycle OFFSET + d0*STR0 + d1*STR1 + d2*STR2, counted from flush release. Presents the current loop indices alongside each pulse.
- Restarts on `flush`.
- One instance per stream port; the accelerator top instantiates it next to the datapath.

Parameters:
- CW, 16, width of the cycle counter, fire-time register and index outputs.
- EXT0, 4, extent of innermost loop d0 (>=1).
- EXT1, 4, extent of middle loop d1 (>=1).
- EXT2, 1, extent of outer loop d2 (>=1).
- STR0, 1, cycle stride of d0 (>=1).
- STR1, 4, cycle stride of d1 (>= EXT0*STR0, which keeps the schedule strictly increasing).
- STR2, 16, cycle stride of d2 (>= (EXT1-1)*STR1 + EXT0*STR0).
- OFFSET, 2, cycles from flush release to the first pulse.
- Elaboration check: last fire time OFFSET + (EXT0-1)*STR0 + (EXT1-1)*STR1 + (EXT2-1)*STR2 < 2^CW, else $error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous restart of the schedule.
- stall  in  1  freezes schedule time; no pulse while high.
- en  out  1  iteration enable (drives a read_en / write_valid).
- d0  out  CW  current innermost index.
- d1  out  CW  current middle index.
- d2  out  CW  current outer index.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low, any time, including mid-run): state=IDLE; cnt=0, fire=OFFSET, d0=d1=d2=0.
  - Outputs during reset: en=0, busy=0, done=0.
- Flush:
  - flush=1 in any state, sampled at a clock edge: next state=RUN; cnt=0, fire=OFFSET, indices=0.
  - en is 0 while flush=1.
  - Flush overrides stall.
  - IDLE leaves only via flush.
- Timebase: cycle 0 is the first cycle with flush=0 after a flush. In RUN with flush=0, stall=0, cnt increments by 1 per clock.
- Pulse:
  - en = (state==RUN) & ~flush & ~stall & (cnt==fire).
  - en is combinational from registers plus flush/stall; no registered latency.
  - Pulses may occur on consecutive cycles.
- On an en cycle (edge at end of cycle), advance indices innermost-first:
  - d0<EXT0-1: d0++.
  - else d0=0; d1<EXT1-1: d1++.
  - else d1=0; d2<EXT2-1: d2++.
  - else the final iteration has fired: state=DONE, indices return to 0.
- Fire time: fire <= OFFSET + d0'*STR0 + d1'*STR1 + d2'*STR2 using the new indices.
  - Constant multiplies; intermediate width CW+clog2 margin, truncated to CW (guaranteed in range by the elaboration check).
- Stall: cnt, fire, indices and state hold; en=0. The schedule resumes exactly where it stopped, so every pending fire is delayed by the stall length.
- DONE: en=0, done=1, busy=0, cnt frozen. DONE is left only by flush or reset.
- Single-iteration nest (EXT0=EXT1=EXT2=1): one pulse at cycle OFFSET, then DONE.
- d0/d1/d2 are valid to consume whenever en=1; at other times they show the next iteration's indices.

Test Plan:
- Defaults (dense schedule): reset, then flush for 1 cycle → en high in cycles 2..17 exactly (16 pulses), (d1,d0) stepping (0,0)..(3,3), done=1 from cycle 18 on, en never high again.
- STR1=6 (sparse): en in cycles 2-5, 8-11, 14-17, 20-23; d1 increments after each group of 4; done from cycle 24.
- Stall: defaults, stall=1 during cycles 5..7 → pulses at cycles 2,3,4, then none while stalled, then resuming at cycle 8 with d0=3,d1=0; last pulse at cycle 20, done at 21.
- Flush mid-run: flush asserted at cycle 9 (after 7 pulses) → en=0 during flush, indices 0; the next pulse is 2 cycles after release, with d0=d1=0; full 16 pulses follow.
- Async reset mid-run: rst_n low at an arbitrary non-edge time → en, busy, done drop immediately; no pulses after reset release until a flush; the post-flush run matches the defaults test.
- EXT0=EXT1=EXT2=1, OFFSET=0: flush released → en in cycle 0 only, done from cycle 1; a second flush reproduces the single pulse.
